// File: rtl/seg7_count_disp.sv
// Prescaled up/down hex/BCD counter driving DIGITS active-low seven-segment outputs.
// Optional leading-zero blanking is enabled by defining SEG7_LZB_EN.
module seg7_count_disp #(
  parameter int unsigned DIGITS   = 8,
  parameter int unsigned PRESCALE = 50000000
) (
  input  logic                  iCLK,
  input  logic                  iRST_N,
  input  logic                  iEN,
  input  logic                  iUP,
  input  logic                  iBCD,
  input  logic                  iCLR,
  input  logic                  iLOAD,
  input  logic [4*DIGITS-1:0]   iLOAD_VAL,
  input  logic                  iLAMP,
  output logic [4*DIGITS-1:0]   oCOUNT,
  output logic [7*DIGITS-1:0]   oHEX,
  output logic                  oTICK,
  output logic                  oWRAP
);

  localparam int unsigned PW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam int unsigned CW = 4 * DIGITS;
  localparam int unsigned HW = 7 * DIGITS;
  localparam logic [PW-1:0] PreMax = PW'(PRESCALE - 1);

  function automatic logic [6:0] glyph(input logic [3:0] d);
    case (d)
      4'h0: glyph = 7'h40;
      4'h1: glyph = 7'h79;
      4'h2: glyph = 7'h24;
      4'h3: glyph = 7'h30;
      4'h4: glyph = 7'h19;
      4'h5: glyph = 7'h12;
      4'h6: glyph = 7'h02;
      4'h7: glyph = 7'h78;
      4'h8: glyph = 7'h00;
      4'h9: glyph = 7'h10;
      4'hA: glyph = 7'h08;
      4'hB: glyph = 7'h03;
      4'hC: glyph = 7'h46;
      4'hD: glyph = 7'h21;
      4'hE: glyph = 7'h06;
      default: glyph = 7'h0E;
    endcase
  endfunction

  // Display of a zero count, used as the reset value.
  function automatic logic [HW-1:0] hex_rst();
    logic [HW-1:0] h;
    for (int k = 0; k < int'(DIGITS); k++) begin
`ifdef SEG7_LZB_EN
      h[7*k +: 7] = (k == 0) ? 7'h40 : 7'h7F;
`else
      h[7*k +: 7] = 7'h40;
`endif
    end
    return h;
  endfunction

  logic [PW-1:0] pre_q, pre_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [HW-1:0] hex_q, hex_d;
  logic          tick_q, tick_d;
  logic          wrap_q, wrap_d;
  logic          bcd_q, bcd_d;

  logic          tick;
  logic          mode_chg;
  logic [CW-1:0] step_val;
  logic          step_wrap;
  logic [CW-1:0] load_san;
  logic [3:0]    dig;
  logic          carry;

  assign tick     = iEN && (pre_q == PreMax);
  assign mode_chg = (iBCD != bcd_q);

  // Stepped count: plain modulo arithmetic in hex, per-digit ripple in BCD.
  always_comb begin
    step_val  = cnt_q;
    step_wrap = 1'b0;
    dig       = '0;
    carry     = 1'b1;
    if (!iBCD) begin
      if (iUP) begin
        step_val  = cnt_q + 1'b1;
        step_wrap = &cnt_q;
      end else begin
        step_val  = cnt_q - 1'b1;
        step_wrap = ~|cnt_q;
      end
    end else begin
      for (int k = 0; k < int'(DIGITS); k++) begin
        dig = cnt_q[4*k +: 4];
        if (carry) begin
          if (iUP) begin
            carry = (dig >= 4'd9);
            dig   = carry ? 4'd0 : dig + 4'd1;
          end else begin
            carry = (dig == 4'd0);
            dig   = carry ? 4'd9 : dig - 4'd1;
          end
        end
        step_val[4*k +: 4] = dig;
      end
      step_wrap = carry;
    end
  end

  always_comb begin
    load_san = iLOAD_VAL;
    for (int k = 0; k < int'(DIGITS); k++) begin
      if (iBCD && (iLOAD_VAL[4*k +: 4] > 4'd9)) begin
        load_san[4*k +: 4] = 4'd9;
      end
    end
  end

  always_comb begin
    bcd_d  = iBCD;
    pre_d  = pre_q;
    cnt_d  = cnt_q;
    tick_d = 1'b0;
    wrap_d = 1'b0;
    if (iCLR || mode_chg) begin
      cnt_d = '0;
      pre_d = '0;
    end else if (iLOAD) begin
      cnt_d = load_san;
      pre_d = '0;
    end else if (tick) begin
      cnt_d  = step_val;
      wrap_d = step_wrap;
      tick_d = 1'b1;
      pre_d  = '0;
    end else if (iEN) begin
      pre_d = pre_q + 1'b1;
    end
  end

  always_comb begin
    hex_d = '0;
    for (int k = 0; k < int'(DIGITS); k++) begin
      hex_d[7*k +: 7] = glyph(cnt_q[4*k +: 4]);
    end
`ifdef SEG7_LZB_EN
    // Walk down from the top digit; blank while everything above is still zero.
    for (int k = int'(DIGITS) - 1; k >= 1; k--) begin
      if (cnt_q[4*k +: 4] != 4'd0) break;
      hex_d[7*k +: 7] = 7'h7F;
    end
`endif
    if (iLAMP) hex_d = '0;
  end

  always_ff @(posedge iCLK or negedge iRST_N) begin
    if (!iRST_N) begin
      pre_q  <= '0;
      cnt_q  <= '0;
      hex_q  <= hex_rst();
      tick_q <= 1'b0;
      wrap_q <= 1'b0;
      bcd_q  <= 1'b0;
    end else begin
      pre_q  <= pre_d;
      cnt_q  <= cnt_d;
      hex_q  <= hex_d;
      tick_q <= tick_d;
      wrap_q <= wrap_d;
      bcd_q  <= bcd_d;
    end
  end

  assign oCOUNT = cnt_q;
  assign oHEX   = hex_q;
  assign oTICK  = tick_q;
  assign oWRAP  = wrap_q;

endmodule

// File: tb/tb_seg7_count_disp.sv
// Directed plus randomized bench for seg7_count_disp (DIGITS=4, PRESCALE=4) against a
// decimal/modular arithmetic reference model.
module tb_seg7_count_disp;

  localparam int DIGITS   = 4;
  localparam int PRESCALE = 4;

  logic        iCLK = 1'b0;
  logic        iRST_N, iEN, iUP, iBCD, iCLR, iLOAD, iLAMP;
  logic [15:0] iLOAD_VAL;
  logic [15:0] oCOUNT;
  logic [27:0] oHEX;
  logic        oTICK, oWRAP;

  seg7_count_disp #(.DIGITS(DIGITS), .PRESCALE(PRESCALE)) dut (
    .iCLK      (iCLK),
    .iRST_N    (iRST_N),
    .iEN       (iEN),
    .iUP       (iUP),
    .iBCD      (iBCD),
    .iCLR      (iCLR),
    .iLOAD     (iLOAD),
    .iLOAD_VAL (iLOAD_VAL),
    .iLAMP     (iLAMP),
    .oCOUNT    (oCOUNT),
    .oHEX      (oHEX),
    .oTICK     (oTICK),
    .oWRAP     (oWRAP)
  );

  always #5 iCLK = ~iCLK;

  int n_vec = 0;
  int n_err = 0;

  logic [6:0] glyphs [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                              7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};

  // Reference state: count value, enabled cycles since last step, expected outputs.
  logic [15:0] m_cnt;
  int          m_pre;
  logic        m_bcd, m_tick, m_wrap;
  logic [27:0] m_hex;

  function automatic logic [27:0] exp_hex(input logic [15:0] c, input logic lamp);
    logic [27:0] h;
    for (int k = 0; k < DIGITS; k++) h[7*k +: 7] = glyphs[c[4*k +: 4]];
`ifdef SEG7_LZB_EN
    for (int k = 1; k < DIGITS; k++) if ((c >> (4*k)) == 16'd0) h[7*k +: 7] = 7'h7F;
`endif
    if (lamp) h = '0;
    return h;
  endfunction

  function automatic int to_dec(input logic [15:0] b);
    int d = 0;
    for (int k = DIGITS - 1; k >= 0; k--) d = d * 10 + int'(b[4*k +: 4]);
    return d;
  endfunction

  function automatic logic [15:0] to_bcd(input int d);
    logic [15:0] b;
    for (int k = 0; k < DIGITS; k++) begin
      b[4*k +: 4] = 4'(d % 10);
      d = d / 10;
    end
    return b;
  endfunction

  task automatic model_reset();
    m_cnt  = '0;
    m_pre  = 0;
    m_bcd  = 1'b0;
    m_tick = 1'b0;
    m_wrap = 1'b0;
    m_hex  = exp_hex(16'd0, 1'b0);
  endtask

  task automatic model_clock();
    logic [15:0] lv;
    int d;
    m_hex  = exp_hex(m_cnt, iLAMP);
    m_tick = 1'b0;
    m_wrap = 1'b0;
    if (iCLR || (iBCD !== m_bcd)) begin
      m_cnt = '0;
      m_pre = 0;
    end else if (iLOAD) begin
      lv = iLOAD_VAL;
      if (iBCD) for (int k = 0; k < DIGITS; k++) if (lv[4*k +: 4] > 9) lv[4*k +: 4] = 4'd9;
      m_cnt = lv;
      m_pre = 0;
    end else if (iEN && m_pre == PRESCALE - 1) begin
      m_pre  = 0;
      m_tick = 1'b1;
      if (!iBCD) begin
        m_wrap = iUP ? (m_cnt == 16'hFFFF) : (m_cnt == 16'h0000);
        m_cnt  = iUP ? 16'(int'(m_cnt) + 1) : 16'(int'(m_cnt) + 65535);
      end else begin
        d      = to_dec(m_cnt);
        m_wrap = iUP ? (d == 9999) : (d == 0);
        m_cnt  = to_bcd(iUP ? (d + 1) % 10000 : (d + 9999) % 10000);
      end
    end else if (iEN) begin
      m_pre++;
    end
    m_bcd = iBCD;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_vec++;
    assert (obs === expv)
    else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, expv);
    end
  endtask

  task automatic check_all();
    chk("count", {16'd0, oCOUNT}, {16'd0, m_cnt});
    chk("tick", {31'd0, oTICK}, {31'd0, m_tick});
    chk("wrap", {31'd0, oWRAP}, {31'd0, m_wrap});
    chk("hex", {4'd0, oHEX}, {4'd0, m_hex});
  endtask

  task automatic step();
    @(posedge iCLK);
    model_clock();
    #1;
    check_all();
  endtask

  task automatic run_to_tick(input int maxc);
    logic got = 1'b0;
    for (int i = 0; i < maxc && !got; i++) begin
      step();
      got = oTICK;
    end
    chk("tick_seen", {31'd0, got}, 32'd1);
  endtask

  initial begin
    iRST_N = 1'b0; iEN = 1'b0; iUP = 1'b1; iBCD = 1'b0; iCLR = 1'b0;
    iLOAD = 1'b0; iLOAD_VAL = '0; iLAMP = 1'b0;
    model_reset();
    #12;
    check_all();
    chk("rst_hex", {4'd0, oHEX}, {4'd0, exp_hex(16'd0, 1'b0)});
    iRST_N = 1'b1;

    // Free count from reset: 40 enabled cycles give ten steps.
    iEN = 1'b1;
    repeat (40) step();
    chk("cnt40", {16'd0, oCOUNT}, 32'h000A);
    step();
    chk("hex_A", {25'd0, oHEX[6:0]}, 32'h08);

    // Hex wrap both directions.
    iLOAD = 1'b1; iLOAD_VAL = 16'hFFFF;
    step();
    iLOAD = 1'b0;
    run_to_tick(8);
    chk("hex_wrap_up_cnt", {16'd0, oCOUNT}, 32'h0000);
    chk("hex_wrap_up_w", {31'd0, oWRAP}, 32'd1);
    step();
`ifdef SEG7_LZB_EN
    chk("hex_zero_disp", {4'd0, oHEX}, {4'd0, 7'h7F, 7'h7F, 7'h7F, 7'h40});
`else
    chk("hex_zero_disp", {4'd0, oHEX}, {4'd0, 7'h40, 7'h40, 7'h40, 7'h40});
`endif
    iUP = 1'b0;
    run_to_tick(8);
    chk("hex_wrap_dn_cnt", {16'd0, oCOUNT}, 32'hFFFF);
    chk("hex_wrap_dn_w", {31'd0, oWRAP}, 32'd1);

    // BCD mode: entry clears, ripple carry and borrow wrap.
    iBCD = 1'b1; iUP = 1'b1;
    step();
    chk("bcd_entry_clr", {16'd0, oCOUNT}, 32'h0000);
    iLOAD = 1'b1; iLOAD_VAL = 16'h0199;
    step();
    iLOAD = 1'b0;
    run_to_tick(8);
    chk("bcd_carry", {16'd0, oCOUNT}, 32'h0200);
    iLOAD = 1'b1; iLOAD_VAL = 16'h0000;
    step();
    iLOAD = 1'b0; iUP = 1'b0;
    run_to_tick(8);
    chk("bcd_borrow", {16'd0, oCOUNT}, 32'h9999);
    chk("bcd_borrow_w", {31'd0, oWRAP}, 32'd1);

    // Load sanitising in BCD, verbatim in hex.
    iLOAD = 1'b1; iLOAD_VAL = 16'h0A5F;
    step();
    chk("bcd_sanitise", {16'd0, oCOUNT}, 32'h0959);
    iLOAD = 1'b0; iBCD = 1'b0;
    step();
    iLOAD = 1'b1;
    step();
    chk("hex_verbatim", {16'd0, oCOUNT}, 32'h0A5F);
    iLOAD = 1'b0; iUP = 1'b1;

    // Clear, load and a due tick in the same cycle.
    repeat (3) step();
    iCLR = 1'b1; iLOAD = 1'b1; iLOAD_VAL = 16'h1234;
    step();
    chk("prio_cnt", {16'd0, oCOUNT}, 32'h0000);
    chk("prio_tick", {31'd0, oTICK}, 32'd0);
    iCLR = 1'b0; iLOAD = 1'b0;

    // Lamp test while counting.
    iLAMP = 1'b1;
    repeat (10) step();
    chk("lamp_hex", {4'd0, oHEX}, 32'd0);
    chk("lamp_cnt", {16'd0, oCOUNT}, 32'h0002);
    iLAMP = 1'b0;
    repeat (2) step();

    // Asynchronous reset mid-prescale.
    iLOAD = 1'b1; iLOAD_VAL = 16'h0023;
    step();
    iLOAD = 1'b0;
    repeat (2) step();
    #2 iRST_N = 1'b0;
    #1;
    model_reset();
    check_all();
    #2 iRST_N = 1'b1;
    repeat (4) step();
    chk("post_rst_cnt", {16'd0, oCOUNT}, 32'h0001);
    chk("post_rst_tick", {31'd0, oTICK}, 32'd1);
    step();
`ifdef SEG7_LZB_EN
    chk("post_rst_hex", {4'd0, oHEX}, {4'd0, 7'h7F, 7'h7F, 7'h7F, 7'h79});
`else
    chk("post_rst_hex", {4'd0, oHEX}, {4'd0, 7'h40, 7'h40, 7'h40, 7'h79});
`endif

    // Randomized traffic.
    for (int i = 0; i < 600; i++) begin
      iEN       = ($urandom % 8) != 0;
      iUP       = ($urandom % 2) != 0;
      if (($urandom % 40) == 0) iBCD = ~iBCD;
      iCLR      = ($urandom % 50) == 0;
      iLOAD     = ($urandom % 25) == 0;
      iLOAD_VAL = 16'($urandom);
      iLAMP     = ($urandom % 6) == 0;
      step();
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
